// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: pointer type and Gray/binary helpers shared by the async FIFO pointer controllers.
package fifo_ptr_pkg;
  // One spare bit above the widest legal pointer (ASIZE=12) keeps callers' upper slices non-empty.
  localparam int PTR_MAX_W = 14;
  typedef logic [PTR_MAX_W-1:0] ptr_t;
  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction
  // Operands are zero-extended into ptr_t, so both conversions are exact for any width up to PTR_MAX_W.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_sync2.sv
// gray_sync2: two-flop synchronizer for Gray pointers crossing clock domains, async active-high reset.
module gray_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
endmodule

// File: rtl/fifo_wptr_full_ctrl.sv
// fifo_wptr_full_ctrl: write-side pointer, full/almost-full/level status of a Gray-code async FIFO.
// Define WPTR_OVF_CHECK_EN to build the sticky wovf overflow flag; otherwise wovf is tied low.
module fifo_wptr_full_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ASIZE        = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             winc,
  input  logic [ASIZE:0]   rptr_gray_async,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr_gray,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wcount,
  output logic             wovf
);
  localparam logic [ASIZE:0] DEPTH_W = (ASIZE+1)'(depth_of(ASIZE));
  localparam logic [ASIZE:0] THRESH  = (ASIZE+1)'(AFULL_THRESH);
  logic [ASIZE:0] wbin, wbnext, wgnext, rq2, rbin, lvl;
  ptr_t wg_wide, rb_wide;
  logic wacc, unused_hi;
  gray_sync2 #(.W(ASIZE+1)) u_rsync (
    .clk   (clk),
    .reset (reset),
    .d     (rptr_gray_async),
    .q     (rq2)
  );
  assign wacc      = winc & ~wfull;
  assign wbnext    = wbin + {{ASIZE{1'b0}}, wacc};
  assign wg_wide   = bin2gray(ptr_t'(wbnext));
  assign wgnext    = wg_wide[ASIZE:0];
  assign rb_wide   = gray2bin(ptr_t'(rq2));
  assign rbin      = rb_wide[ASIZE:0];
  assign lvl       = wbnext - rbin;
  assign unused_hi = ^{wg_wide[PTR_MAX_W-1:ASIZE+1], rb_wide[PTR_MAX_W-1:ASIZE+1]};
  assign waddr     = wbin[ASIZE-1:0];
  // Full when the next write pointer equals the synced read pointer with its top two Gray bits inverted.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
    end else begin
      wbin         <= wbnext;
      wptr_gray    <= wgnext;
      wfull        <= wgnext == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]};
      walmost_full <= (DEPTH_W - lvl) <= THRESH;
      wcount       <= lvl;
    end
`ifdef WPTR_OVF_CHECK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) wovf <= 1'b0;
    else wovf <= wovf | (winc & wfull);
`else
  assign wovf = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// tb_fifo_wptr_full_ctrl: directed self-checking bench, ASIZE=2 (depth 4), AFULL_THRESH=1.
module tb_fifo_wptr_full_ctrl;
  logic       clk = 1'b0;
  logic       reset, winc;
  logic [2:0] rptr_gray_async;
  logic [1:0] waddr;
  logic [2:0] wptr_gray, wcount, prev_g;
  logic       wfull, walmost_full, wovf, exp_ovf;
  int checks = 0;
  int errors = 0;
  logic [2:0] g_fill [4]  = '{3'b001, 3'b011, 3'b010, 3'b110};
  logic [2:0] g_seq  [11] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                              3'b101, 3'b100, 3'b000, 3'b001, 3'b011};

  fifo_wptr_full_ctrl #(.ASIZE(2), .AFULL_THRESH(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .winc            (winc),
    .rptr_gray_async (rptr_gray_async),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .wfull           (wfull),
    .walmost_full    (walmost_full),
    .wcount          (wcount),
    .wovf            (wovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_waddr"}, 32'(waddr), 0);
    chk({tag, "_gray"}, 32'(wptr_gray), 0);
    chk({tag, "_full"}, 32'(wfull), 0);
    chk({tag, "_afull"}, 32'(walmost_full), 0);
    chk({tag, "_count"}, 32'(wcount), 0);
    chk({tag, "_ovf"}, 32'(wovf), 0);
  endtask

  initial begin
`ifdef WPTR_OVF_CHECK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    reset = 1'b1;
    winc = 1'b0;
    rptr_gray_async = 3'b000;
    repeat (2) tick();
    reset = 1'b0;
    chk_zero("por");
    winc = 1'b1;
    repeat (3) tick();
    chk("pre_rst_waddr", 32'(waddr), 3);
    chk("pre_rst_gray", 32'(wptr_gray), 32'b010);
    #2 reset = 1'b1;
    #1 chk_zero("async_rst");
    winc = 1'b0;
    #1 reset = 1'b0;
    winc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_waddr", 32'(waddr), 32'(i));
      tick();
      chk("fill_gray", 32'(wptr_gray), 32'(g_fill[i]));
      chk("fill_afull", 32'(walmost_full), 32'(i >= 2));
      chk("fill_full", 32'(wfull), 32'(i == 3));
    end
    chk("fill_count", 32'(wcount), 4);
    repeat (2) begin
      tick();
      chk("ovf_gray_hold", 32'(wptr_gray), 32'b110);
      chk("ovf_waddr_hold", 32'(waddr), 0);
      chk("ovf_full", 32'(wfull), 1);
    end
    chk("ovf_flag", 32'(wovf), 32'(exp_ovf));
    winc = 1'b0;
    rptr_gray_async = 3'b001;
    tick();
    chk("rd_edge1_full", 32'(wfull), 1);
    tick();
    chk("rd_edge2_full", 32'(wfull), 1);
    tick();
    chk("rd_edge3_full", 32'(wfull), 0);
    chk("rd_edge3_count", 32'(wcount), 3);
    chk("rd_edge3_afull", 32'(walmost_full), 1);
    winc = 1'b1;
    tick();
    chk("refill_full", 32'(wfull), 1);
    chk("refill_gray", 32'(wptr_gray), 32'b111);
    chk("refill_waddr", 32'(waddr), 1);
    chk("refill_count", 32'(wcount), 4);
    chk("refill_ovf", 32'(wovf), 32'(exp_ovf));
    winc = 1'b0;
    #2 reset = 1'b1;
    #1 chk_zero("rst2");
    #1 reset = 1'b0;
    // Read side tracks the current write pointer; the synchronizer makes it lag by two.
    for (int i = 0; i < 10; i++) begin
      rptr_gray_async = g_seq[i];
      winc = 1'b1;
      prev_g = wptr_gray;
      tick();
      chk("wrap_gray", 32'(wptr_gray), 32'(g_seq[i+1]));
      chk("wrap_onebit", 32'($countones(prev_g ^ wptr_gray)), 1);
      chk("wrap_nofull", 32'(wfull), 0);
    end
    chk("wrap_count", 32'(wcount), 3);
    chk("wrap_ovf", 32'(wovf), 0);
    winc = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_wptr_full_ctrl.md
Name: fifo_wptr_full_ctrl

Overview:
Write-side pointer controller for the team's Gray-code async FIFOs. It owns the binary write counter and its Gray mirror, and synchronizes the read-side Gray pointer into the write clock domain. From these it computes registered full, almost-full, fill-level and overflow status. It sits between the write requester and the dual-port FIFO RAM, and pairs with the read-side empty controller.

Parameters:
ASIZE, 4, RAM address width; FIFO depth = 2**ASIZE; legal range 2..12
AFULL_THRESH, 2, walmost_full asserts when free slots <= AFULL_THRESH; legal range 0..2**ASIZE

Ports:
clk  in  1  write-domain clock, rising edge
reset  in  1  asynchronous active-high reset; assertion is asynchronous and clears all state
winc  in  1  write request; accepted only when wfull=0
rptr_gray_async  in  ASIZE+1  read-domain Gray pointer, asynchronous to clk
waddr  out  ASIZE  RAM write address: low ASIZE bits of the binary write pointer
wptr_gray  out  ASIZE+1  registered Gray write pointer, exported to the read domain
wfull  out  1  registered full flag
walmost_full  out  1  registered almost-full flag
wcount  out  ASIZE+1  registered fill level as seen from the write side, 0..2**ASIZE
wovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset: wbin, wptr_gray, the two synchronizer stages, wfull, walmost_full, wcount and wovf are all 0.
- Synchronizer: rq1 <= rptr_gray_async; rq2 <= rq1. Only rq2 is used. Read-pointer movement is visible 2 edges later, so full is pessimistic and never optimistic.
- Write accept: wacc = winc & ~wfull.
- Next pointers: wbnext = wbin + wacc (mod 2**(ASIZE+1)); wgnext = (wbnext>>1) ^ wbnext.
- Pointer update: each edge, wbin <= wbnext and wptr_gray <= wgnext. waddr = wbin[ASIZE-1:0], combinational from the register.
- Full: wfull <= (wgnext == {~rq2[ASIZE:ASIZE-1], rq2[ASIZE-2:0]}). wfull rises on the same edge as the write that fills the last slot. There are no bubbles.
- Read-pointer conversion: rbin = gray-to-binary(rq2).
- Fill level: wcount <= wbnext - rbin (ASIZE+1 bits, modular; result is always <= 2**ASIZE).
- Almost full: walmost_full <= ((2**ASIZE - (wbnext - rbin)) <= AFULL_THRESH).
  - With AFULL_THRESH=0, walmost_full equals wfull.
  - With AFULL_THRESH >= depth, walmost_full stays 1 out of reset.
- winc while wfull=1: ignored. Pointers hold and no RAM write occurs.
- winc on the cycle wfull deasserts: accepted, because wfull is the registered value.
- Wrap-around: after binary 2**(ASIZE+1)-1 the pointer wraps to 0. The Gray code changes one bit per increment, including at wrap.
- Simultaneous read movement and write: no special case. Both feed the same next-state equations.
- Reset mid-operation: everything returns to 0 immediately and asynchronously. The read side must be reset in the same reset event; the controller does not check this.
- All outputs are registered except waddr, which is a direct slice of a register.

Optional Feature:
Macro WPTR_OVF_CHECK_EN.
- Defined: wovf <= wovf | (winc & wfull). wovf is sticky until reset.
- Not defined: wovf is tied to 0 and the extra flop is not synthesized.
Overflow behaviour is the same in both builds: the write is dropped.

Decomposition:
- Package fifo_ptr_pkg:
  - functions bin2gray and gray2bin, parameterized by width
  - typedef for the pointer type (ASIZE+1 bits)
  - localparam DEPTH = 2**ASIZE helper
- Sub-module gray_sync2: a 2-flop synchronizer with width parameter and async active-high reset. It is reused by the read-side controller.

Test Plan:
All scenarios use ASIZE=2 (depth 4) and AFULL_THRESH=1; "edge" means rising edge of clk.
1. Reset asserted mid-stream with wbin=3 -> immediately waddr=0, wptr_gray=000, wfull=0, wcount=0, wovf=0.
2. rptr_gray_async=000; winc=1 for 4 cycles ->
   - waddr sequence 0,1,2,3
   - wptr_gray sequence 001,011,010,110
   - walmost_full=1 after the 3rd edge
   - wfull=1 after the 4th edge
   - wcount=4
3. With FIFO full, winc=1 for 2 more cycles -> wptr_gray holds 110 and waddr holds 0. wovf=1 when WPTR_OVF_CHECK_EN is defined, 0 otherwise.
4. From full, rptr_gray_async changes 000->001 -> wfull clears on the 3rd edge after the change; wcount=3 on that same edge.
5. Run 10 continuous writes and reads, with rptr lagging by 2 -> wptr_gray passes 100 then 000 at wrap. Exactly one Gray bit changes per edge, and there is no spurious wfull.
6. Assert winc on the exact cycle wfull deasserts -> the write is accepted and wfull re-asserts on the next edge.
